spi_cmd_master: RTL and testbench

//  Command-level master that drives the SPI RAM wrapper's serial port (SS_n/MOSI/MISO) on the shared system clock.

---
 rtl/spi_cmd_master_if.sv | 23 ++
 rtl/spi_cmd_master.sv | 130 +++++++++++++
 tb/tb_spi_cmd_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_master_if.sv
// Command-side bus of spi_cmd_master: one command per valid/ready handshake,
// read bytes returned with a one-cycle rd_valid pulse.
interface spi_cmd_master_if #(
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_type;
   logic [DATA_W-1:0] cmd_data;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              busy;

   modport master (
      output cmd_valid, cmd_type, cmd_data,
      input  cmd_ready, rd_valid, rd_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_data,
      output cmd_ready, rd_valid, rd_data, busy
   );
endinterface

// File: rtl/spi_cmd_master.sv
// Serialises {cmd_type, cmd_data} commands into SS_n/MOSI frames for the SPI RAM
// wrapper and, for read-data commands, collects the MISO reply byte.
module spi_cmd_master #(
   parameter int DATA_W   = 8,
   parameter int TURN_CYC = 2,
   parameter int GAP_CYC  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_cmd_master_if.slave       bus,
   output logic                  SS_n,
   output logic                  MOSI,
   input  logic                  MISO
);
   localparam int SHIFT_N = DATA_W + 2;
   localparam int MAX_A   = (SHIFT_N > TURN_CYC) ? SHIFT_N : TURN_CYC;
   localparam int MAX_N   = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_N);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_N - 1);
   localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYC - 1);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, START, SEL, SHIFT, TURN, RECV, GAP
   } state_t;

   state_t              state;
   logic [SHIFT_N-1:0]  shreg;
   logic [DATA_W-1:0]   rxreg;
   logic [CNT_W-1:0]    cnt;
   logic                rd_cmd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         shreg         <= '0;
         rxreg         <= '0;
         cnt           <= '0;
         rd_cmd        <= 1'b0;
         SS_n          <= 1'b1;
         MOSI          <= 1'b0;
         bus.cmd_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.rd_valid  <= 1'b0;
         bus.rd_data   <= '0;
      end else begin
         bus.rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  shreg         <= {bus.cmd_type, bus.cmd_data};
                  rd_cmd        <= (bus.cmd_type == 2'b11);
                  state         <= START;
                  SS_n          <= 1'b0;
                  MOSI          <= 1'b0;
                  bus.cmd_ready <= 1'b0;
                  bus.busy      <= 1'b1;
               end
            end
            START: begin
               // Select bit is cmd_type[1], which is also the first shifted bit
               MOSI  <= shreg[SHIFT_N-1];
               state <= SEL;
            end
            SEL: begin
               MOSI  <= shreg[SHIFT_N-1];
               shreg <= shreg << 1;
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               if (cnt == SHIFT_LAST) begin
                  MOSI <= 1'b0;
                  cnt  <= '0;
                  if (rd_cmd) begin
                     state <= TURN;
                  end else begin
                     SS_n  <= 1'b1;
                     state <= GAP;
                  end
               end else begin
                  MOSI  <= shreg[SHIFT_N-1];
                  shreg <= shreg << 1;
                  cnt   <= cnt + 1'b1;
               end
            end
            TURN: begin
               if (cnt == TURN_LAST) begin
                  cnt   <= '0;
                  state <= RECV;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RECV: begin
               // MISO only enters the datapath here, so junk elsewhere is harmless
               rxreg <= {rxreg[DATA_W-2:0], MISO};
               if (cnt == RECV_LAST) begin
                  bus.rd_data  <= {rxreg[DATA_W-2:0], MISO};
                  bus.rd_valid <= 1'b1;
                  SS_n         <= 1'b1;
                  cnt          <= '0;
                  state        <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt           <= '0;
                  bus.cmd_ready <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state         <= IDLE;
               SS_n          <= 1'b1;
               MOSI          <= 1'b0;
               bus.cmd_ready <= 1'b1;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench: two masters (TURN_CYC 2 and 3) with a MISO reply model and
// frame monitors recording SS_n-low length and the MOSI bits of each frame.
module tb_spi_cmd_master;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_cmd_master_if #(.DATA_W(8)) bus0 ();
   spi_cmd_master_if #(.DATA_W(8)) bus1 ();

   logic       ss0, ss1, mosi0, mosi1;
   logic [1:0] miso_v = 2'b11;
   logic [1:0] ss_v, mosi_v, rv_v;
   assign ss_v   = {ss1, ss0};
   assign mosi_v = {mosi1, mosi0};
   assign rv_v   = {bus1.rd_valid, bus0.rd_valid};

   spi_cmd_master #(.DATA_W(8), .TURN_CYC(2), .GAP_CYC(1)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .SS_n(ss0), .MOSI(mosi0), .MISO(miso_v[0]));
   spi_cmd_master #(.DATA_W(8), .TURN_CYC(3), .GAP_CYC(1)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .SS_n(ss1), .MOSI(mosi1), .MISO(miso_v[1]));

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lowcnt [2] = '{0, 0};
   bit          inlow [2] = '{0, 0};
   logic [31:0] hist [2] = '{0, 0};
   logic [31:0] hlog [2][16];
   int          llog [2][16];
   int          frames [2] = '{0, 0};
   int          rvc [2] = '{0, 0};
   logic [7:0]  rxbyte [2] = '{8'h00, 8'h00};
   int          turn_c [2] = '{2, 3};

   always @(posedge clk) cyc <= cyc + 1;

   // Frame monitor plus MISO reply model: drives the reply byte MSB first during
   // the RECV window and 1s everywhere else.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int idx, r;
         idx = inlow[k] ? lowcnt[k] : 0;
         r   = idx - 12 - turn_c[k];
         if (!ss_v[k] && r >= 0 && r < 8) miso_v[k] <= rxbyte[k][7-r];
         else miso_v[k] <= 1'b1;
         if (!ss_v[k]) begin
            if (!inlow[k]) begin
               hist[k]   <= {31'b0, mosi_v[k]};
               lowcnt[k] <= 1;
               inlow[k]  <= 1'b1;
            end else begin
               hist[k]   <= {hist[k][30:0], mosi_v[k]};
               lowcnt[k] <= lowcnt[k] + 1;
            end
         end else if (inlow[k]) begin
            inlow[k]                 <= 1'b0;
            hlog[k][frames[k] & 15]  <= hist[k];
            llog[k][frames[k] & 15]  <= lowcnt[k];
            frames[k]                <= frames[k] + 1;
         end
         if (rv_v[k]) rvc[k] <= rvc[k] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int k, input logic [1:0] t, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (((k == 0) ? bus0.cmd_ready : bus1.cmd_ready) !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_ready_timeout", 32'(n < 100), 32'd1);
      if (k == 0) begin
         bus0.cmd_valid = 1'b1; bus0.cmd_type = t; bus0.cmd_data = d;
      end else begin
         bus1.cmd_valid = 1'b1; bus1.cmd_type = t; bus1.cmd_data = d;
      end
      @(posedge clk);
      #1;
      bus0.cmd_valid = 1'b0;
      bus1.cmd_valid = 1'b0;
   endtask

   function automatic logic [31:0] last_hist(input int k);
      return hlog[k][(frames[k] - 1) & 15];
   endfunction

   function automatic int last_len(input int k);
      return llog[k][(frames[k] - 1) & 15];
   endfunction

   initial begin
      int f0, r0, t1, t2, n;
      bus0.cmd_valid = 1'b0; bus0.cmd_type = 2'b00; bus0.cmd_data = 8'h00;
      bus1.cmd_valid = 1'b0; bus1.cmd_type = 2'b00; bus1.cmd_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ss_n", 32'(ss0), 32'd1);
      check("rst_mosi", 32'(mosi0), 32'd0);
      check("rst_ready", 32'(bus0.cmd_ready), 32'd1);
      check("rst_busy", 32'(bus0.busy), 32'd0);
      check("rst_rd_valid", 32'(bus0.rd_valid), 32'd0);
      check("rst_rd_data", 32'(bus0.rd_data), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Write address 00/0x3C
      f0 = frames[0]; r0 = rvc[0];
      send(0, 2'b00, 8'h3C);
      check("acc_busy", 32'(bus0.busy), 32'd1);
      check("acc_ready", 32'(bus0.cmd_ready), 32'd0);
      check("acc_ss_n", 32'(ss0), 32'd0);
      repeat (20) @(negedge clk);
      check("wa_frames", 32'(frames[0] - f0), 32'd1);
      check("wa_len", 32'(last_len(0)), 32'd12);
      check("wa_mosi", last_hist(0), 32'h03C);
      check("wa_no_rdv", 32'(rvc[0] - r0), 32'd0);

      // Write data then read address with cmd_valid held
      f0 = frames[0];
      @(negedge clk);
      bus0.cmd_valid = 1'b1; bus0.cmd_type = 2'b01; bus0.cmd_data = 8'hA7;
      n = 0;
      while (bus0.cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      t1 = cyc;
      @(posedge clk); #1;
      bus0.cmd_type = 2'b10; bus0.cmd_data = 8'h3C;
      @(negedge clk);
      while (bus0.cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("b2b_timeout", 32'(n < 100), 32'd1);
      t2 = cyc;
      @(posedge clk); #1;
      bus0.cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("b2b_spacing", 32'(t2 - t1), 32'd14);
      check("b2b_frames", 32'(frames[0] - f0), 32'd2);
      check("wd_mosi", hlog[0][f0 & 15], 32'h1A7);
      check("ra_mosi", hlog[0][(f0 + 1) & 15], 32'h63C);
      check("ra_len", 32'(llog[0][(f0 + 1) & 15]), 32'd12);

      // Read data on the TURN_CYC=2 master, reply 0xA7
      rxbyte[0] = 8'hA7;
      r0 = rvc[0];
      send(0, 2'b11, 8'h00);
      repeat (30) @(negedge clk);
      check("rd_pulses", 32'(rvc[0] - r0), 32'd1);
      check("rd_data", 32'(bus0.rd_data), 32'hA7);
      check("rd_len", 32'(last_len(0)), 32'd22);
      check("rd_mosi", last_hist(0), 32'h1C0000);

      // Read data on the TURN_CYC=3 master, reply 0x5A
      rxbyte[1] = 8'h5A;
      r0 = rvc[1];
      send(1, 2'b11, 8'hFF);
      repeat (30) @(negedge clk);
      check("rd3_pulses", 32'(rvc[1] - r0), 32'd1);
      check("rd3_data", 32'(bus1.rd_data), 32'h5A);
      check("rd3_len", 32'(last_len(1)), 32'd23);
      check("rd3_mosi", last_hist(1), 32'h3FF800);

      // cmd_valid pulsed while busy is dropped
      f0 = frames[0]; r0 = rvc[0];
      send(0, 2'b01, 8'h55);
      repeat (3) @(negedge clk);
      check("busy_ready", 32'(bus0.cmd_ready), 32'd0);
      bus0.cmd_valid = 1'b1; bus0.cmd_type = 2'b00; bus0.cmd_data = 8'h11;
      @(negedge clk);
      bus0.cmd_valid = 1'b0;
      repeat (30) @(negedge clk);
      check("ign_frames", 32'(frames[0] - f0), 32'd1);
      check("ign_mosi", last_hist(0), 32'h155);
      check("wr_keeps_rd_data", 32'(bus0.rd_data), 32'hA7);
      check("wr_no_rdv", 32'(rvc[0] - r0), 32'd0);

      // Asynchronous reset in the middle of a read frame
      r0 = rvc[0];
      send(0, 2'b11, 8'h00);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ss_n", 32'(ss0), 32'd1);
      check("arst_mosi", 32'(mosi0), 32'd0);
      check("arst_ready", 32'(bus0.cmd_ready), 32'd1);
      check("arst_busy", 32'(bus0.busy), 32'd0);
      check("arst_rd_valid", 32'(bus0.rd_valid), 32'd0);
      check("arst_rd_data", 32'(bus0.rd_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("arst_no_rdv", 32'(rvc[0] - r0), 32'd0);
      check("arst_idle_ss_n", 32'(ss0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
